add_reservation_station: RTL and testbench

Adder reservation station of the dual-issue Tomasulo core. Dispatch/decode and the register file drive it through the add source mux. It holds add instructions until both operands are values, snooping the common data bus (CDB) for pending tags. It issues ready entries to an internal pipelined 32-bit adder and presents each result with its producer tag to the CDB arbitrator.

---
 rtl/add_reservation_station.sv | 206 ++++++++++++++++++++
 tb/tb_add_reservation_station.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/add_reservation_station.sv
// Adder reservation station: holds add instructions until both operands are values, snooping the CDB,
// then issues them to a pipelined 32-bit adder. Define ADD_RS_AGE_PRIORITY_EN for oldest-first issue.
module add_reservation_station #(
  parameter int          NUM_ENTRIES = 4,
  parameter int          ADD_LATENCY = 2,
  parameter logic [4:0]  TAG_PREFIX  = 5'b10100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [31:0] src_in_1,
  input  logic [31:0] src_in_2,
  input  logic        src_in1_type,
  input  logic        src_in2_type,
  input  logic        src_in_valid,
  input  logic [31:0] data_in_CDB,
  input  logic [7:0]  tag_in_CDB,
  output logic        data_out_valid,
  output logic [31:0] data_out,
  output logic [7:0]  reg_tag_out,
  output logic        ready_for_instr,
  output logic [7:0]  acceptor_tag
);

  localparam int DATA_W = 32;
  localparam int PS     = ADD_LATENCY;

  typedef enum logic [1:0] {ST_FREE, ST_WAIT, ST_READY, ST_EXEC} st_e;

  st_e                state [NUM_ENTRIES];
  logic [DATA_W-1:0]  op1   [NUM_ENTRIES];
  logic [DATA_W-1:0]  op2   [NUM_ENTRIES];
  logic               t1    [NUM_ENTRIES];
  logic               t2    [NUM_ENTRIES];
  logic               snp1  [NUM_ENTRIES];
  logic               snp2  [NUM_ENTRIES];
`ifdef ADD_RS_AGE_PRIORITY_EN
  logic [7:0]         age   [NUM_ENTRIES];
  logic [7:0]         best_age;
`endif

  logic               free_found, alloc_go;
  logic [2:0]         alloc_idx;
  logic               issue_found, issue_go;
  logic [2:0]         issue_idx;
  logic [DATA_W-1:0]  issue_sum;
  logic               cdb_v;
  logic               fwd1, fwd2, disp_t1, disp_t2;
  logic [DATA_W-1:0]  disp_v1, disp_v2;

  logic               vld_p [PS];
  logic [DATA_W-1:0]  sum_p [PS];
  logic [2:0]         idx_p [PS];
  logic               retire_go;
  logic [2:0]         retire_idx;
  logic [DATA_W-1:0]  retire_sum;

  assign cdb_v = tag_in_CDB[7];

  // Same-cycle forwarding of a dispatched tag that is on the CDB right now
  assign fwd1    = src_in1_type && cdb_v && (src_in_1[7:0] == tag_in_CDB);
  assign fwd2    = src_in2_type && cdb_v && (src_in_2[7:0] == tag_in_CDB);
  assign disp_t1 = src_in1_type && !fwd1;
  assign disp_t2 = src_in2_type && !fwd2;
  assign disp_v1 = fwd1 ? data_in_CDB : src_in_1;
  assign disp_v2 = fwd2 ? data_in_CDB : src_in_2;

  always_comb begin
    free_found = 1'b0;
    alloc_idx  = 3'd0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (state[i] == ST_FREE) begin
        free_found = 1'b1;
        alloc_idx  = 3'(i);
      end
    end
  end

  assign ready_for_instr = free_found;
  assign acceptor_tag    = free_found ? {TAG_PREFIX, alloc_idx} : 8'h00;
  assign alloc_go        = en && src_in_valid && free_found;

  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      snp1[i] = t1[i] && cdb_v && (op1[i][7:0] == tag_in_CDB);
      snp2[i] = t2[i] && cdb_v && (op2[i][7:0] == tag_in_CDB);
    end
  end

  always_comb begin
    issue_found = 1'b0;
    issue_idx   = 3'd0;
    issue_sum   = '0;
`ifdef ADD_RS_AGE_PRIORITY_EN
    best_age    = 8'd0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (state[i] == ST_READY && (!issue_found || age[i] > best_age)) begin
        issue_found = 1'b1;
        issue_idx   = 3'(i);
        issue_sum   = op1[i] + op2[i];
        best_age    = age[i];
      end
    end
`else
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (state[i] == ST_READY && !issue_found) begin
        issue_found = 1'b1;
        issue_idx   = 3'(i);
        issue_sum   = op1[i] + op2[i];
      end
    end
`endif
  end

  assign issue_go   = en && issue_found;
  assign retire_go  = en && vld_p[PS-1];
  assign retire_idx = idx_p[PS-1];
  assign retire_sum = sum_p[PS-1];

  // Entry control: retire beats issue beats allocation beats snoop wakeup
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        state[i] <= ST_FREE;
`ifdef ADD_RS_AGE_PRIORITY_EN
        age[i]   <= 8'd0;
`endif
      end
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (retire_go && retire_idx == 3'(i)) begin
          state[i] <= ST_FREE;
        end else if (issue_go && issue_idx == 3'(i)) begin
          state[i] <= ST_EXEC;
        end else if (alloc_go && alloc_idx == 3'(i)) begin
          state[i] <= (disp_t1 || disp_t2) ? ST_WAIT : ST_READY;
        end else if (state[i] == ST_WAIT && !(t1[i] && !snp1[i]) && !(t2[i] && !snp2[i])) begin
          state[i] <= ST_READY;
        end
`ifdef ADD_RS_AGE_PRIORITY_EN
        if (alloc_go && alloc_idx == 3'(i))
          age[i] <= 8'd0;
        else if (state[i] != ST_FREE && age[i] != 8'hFF)
          age[i] <= age[i] + 8'd1;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (alloc_go && alloc_idx == 3'(i)) begin
        op1[i] <= disp_v1;
        op2[i] <= disp_v2;
        t1[i]  <= disp_t1;
        t2[i]  <= disp_t2;
      end else if (state[i] == ST_WAIT) begin
        if (snp1[i]) begin
          op1[i] <= data_in_CDB;
          t1[i]  <= 1'b0;
        end
        if (snp2[i]) begin
          op2[i] <= data_in_CDB;
          t2[i]  <= 1'b0;
        end
      end
    end
  end

  // Adder pipeline: _p0 captures the issued sum, later stages shift while en is high
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < PS; s++) vld_p[s] <= 1'b0;
    end else if (en) begin
      vld_p[0] <= issue_go;
      for (int s = 1; s < PS; s++) vld_p[s] <= vld_p[s-1];
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      sum_p[0] <= issue_sum;
      idx_p[0] <= issue_idx;
      for (int s = 1; s < PS; s++) begin
        sum_p[s] <= sum_p[s-1];
        idx_p[s] <= idx_p[s-1];
      end
    end
  end

  // Output register: one-cycle result strobe toward the CDB arbitrator
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out_valid <= 1'b0;
      data_out       <= '0;
      reg_tag_out    <= 8'h00;
    end else if (en) begin
      data_out_valid <= retire_go;
      data_out       <= retire_go ? retire_sum : '0;
      reg_tag_out    <= retire_go ? {TAG_PREFIX, retire_idx} : 8'h00;
    end else begin
      data_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_add_reservation_station.sv
// Scoreboard bench for add_reservation_station: stimulus pushes expected {tag,data}, a monitor pops on data_out_valid.
module tb_add_reservation_station;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [31:0] src_in_1, src_in_2;
  logic        src_in1_type, src_in2_type, src_in_valid;
  logic [31:0] data_in_CDB;
  logic [7:0]  tag_in_CDB;
  logic        data_out_valid;
  logic [31:0] data_out;
  logic [7:0]  reg_tag_out;
  logic        ready_for_instr;
  logic [7:0]  acceptor_tag;

  int          checks = 0;
  int          errors = 0;
  logic [39:0] exp_q[$];
  logic [39:0] mon_e;

  always #5 clk = ~clk;

  add_reservation_station dut (
    .clk            (clk),
    .reset          (reset),
    .en             (en),
    .src_in_1       (src_in_1),
    .src_in_2       (src_in_2),
    .src_in1_type   (src_in1_type),
    .src_in2_type   (src_in2_type),
    .src_in_valid   (src_in_valid),
    .data_in_CDB    (data_in_CDB),
    .tag_in_CDB     (tag_in_CDB),
    .data_out_valid (data_out_valid),
    .data_out       (data_out),
    .reg_tag_out    (reg_tag_out),
    .ready_for_instr(ready_for_instr),
    .acceptor_tag   (acceptor_tag)
  );

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset && data_out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got tag=%h data=%h, expected no result", reg_tag_out, data_out);
      end else begin
        mon_e = exp_q.pop_front();
        chk("result", {reg_tag_out, data_out}, mon_e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dispatch(input logic [31:0] v1, input logic ty1, input logic [31:0] v2, input logic ty2);
    src_in_1     = v1;
    src_in1_type = ty1;
    src_in_2     = v2;
    src_in2_type = ty2;
    src_in_valid = 1'b1;
    tick();
    src_in_valid = 1'b0;
  endtask

  task automatic cdb(input logic [7:0] tag, input logic [31:0] data);
    tag_in_CDB  = tag;
    data_in_CDB = data;
    tick();
    tag_in_CDB  = 8'h00;
    data_in_CDB = 32'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; en = 1'b1;
    src_in_1 = 0; src_in_2 = 0; src_in1_type = 0; src_in2_type = 0; src_in_valid = 0;
    data_in_CDB = 0; tag_in_CDB = 0;
    #1;
    chk("reset_outputs", {7'd0, data_out_valid, reg_tag_out, data_out}, 40'h0);
    repeat (2) tick();
    reset = 1'b1;
    chk("ready_after_reset", {39'd0, ready_for_instr}, 40'd1);
    chk("acceptor_after_reset", {32'd0, acceptor_tag}, 40'hA0);

    // 5 + 7, result three edges after the dispatch edge
    exp_q.push_back({8'hA0, 32'd12});
    dispatch(32'd5, 1'b0, 32'd7, 1'b0);
    chk("acceptor_after_dispatch", {32'd0, acceptor_tag}, 40'hA1);
    tick();
    chk("valid_e1", {39'd0, data_out_valid}, 40'd0);
    tick();
    chk("valid_e2", {39'd0, data_out_valid}, 40'd0);
    tick();
    chk("valid_e3", {39'd0, data_out_valid}, 40'd1);
    chk("acceptor_freed", {32'd0, acceptor_tag}, 40'hA0);
    tick();
    chk("valid_e4", {39'd0, data_out_valid}, 40'd0);

    // Pending tag woken by CDB
    dispatch(32'h0000_00C2, 1'b1, 32'd10, 1'b0);
    repeat (4) tick();
    chk("wait_holds_entry", {32'd0, acceptor_tag}, 40'hA1);
    exp_q.push_back({8'hA0, 32'd13});
    cdb(8'hC2, 32'd3);
    repeat (5) tick();

    // Same-cycle forwarding
    exp_q.push_back({8'hA0, 32'd21});
    tag_in_CDB = 8'h81; data_in_CDB = 32'd20;
    dispatch(32'h0000_0081, 1'b1, 32'd1, 1'b0);
    tag_in_CDB = 8'h00; data_in_CDB = 32'd0;
    repeat (5) tick();

    // Fill all entries with pending tags
    for (int i = 0; i < 4; i++) dispatch(32'h90 + i, 1'b1, i, 1'b0);
    chk("full_ready", {39'd0, ready_for_instr}, 40'd0);
    chk("full_acceptor", {32'd0, acceptor_tag}, 40'h00);
    dispatch(32'd100, 1'b0, 32'd100, 1'b0);
    repeat (3) tick();
    chk("full_still", {39'd0, ready_for_instr}, 40'd0);
    exp_q.push_back({8'hA2, 32'd52});
    cdb(8'h92, 32'd50);
    tick();
    tick();
    chk("full_before_retire", {39'd0, ready_for_instr}, 40'd0);
    tick();
    chk("ready_after_retire", {39'd0, ready_for_instr}, 40'd1);
    chk("acceptor_after_retire", {32'd0, acceptor_tag}, 40'hA2);
    exp_q.push_back({8'hA0, 32'd1});
    exp_q.push_back({8'hA1, 32'd3});
    exp_q.push_back({8'hA3, 32'd6});
    cdb(8'h90, 32'd1);
    cdb(8'h91, 32'd2);
    cdb(8'h93, 32'd3);
    repeat (8) tick();
    chk("all_free", {32'd0, acceptor_tag}, 40'hA0);

    // Carry out is discarded
    exp_q.push_back({8'hA0, 32'h0000_0001});
    dispatch(32'hFFFF_FFFF, 1'b0, 32'd2, 1'b0);
    repeat (5) tick();

    // en low blocks allocation
    en = 1'b0;
    dispatch(32'd1, 1'b0, 32'd1, 1'b0);
    chk("en_low_no_alloc", {32'd0, acceptor_tag}, 40'hA0);
    en = 1'b1;
    repeat (4) tick();

    // Reset while a result is on the output and another entry is in flight
    dispatch(32'd1, 1'b0, 32'd1, 1'b0);
    dispatch(32'd3, 1'b0, 32'd4, 1'b0);
    tick();
    tick();
    chk("pre_reset_result", {reg_tag_out, data_out}, {8'hA0, 32'd2});
    reset = 1'b0;
    #1;
    chk("reset_mid_outputs", {7'd0, data_out_valid, reg_tag_out, data_out}, 40'h0);
    chk("reset_mid_acceptor", {32'd0, acceptor_tag}, 40'hA0);
    tick();
    reset = 1'b1;
    repeat (6) tick();
    chk("scoreboard_drained", 40'(exp_q.size()), 40'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
